// File: rtl/pwm_capture_if.sv
// pwm_capture_if: signal bundle between a PWM capture block and its user.
//   enable       : measurement enable (user -> capture)
//   pwm_in       : asynchronous PWM waveform (source -> capture)
//   high_count   : high time of the last complete period, in clock cycles
//   period_count : rising edge to rising edge time, in clock cycles
//   valid        : one-cycle strobe, counts updated this cycle
//   timeout      : no rising edge seen for 2^CNT_W-1 cycles (sticky)
//   stuck_level  : synchronised line level when timeout was raised
// master = the side that drives enable/pwm_in; slave = the capture block.
interface pwm_capture_if #(
  parameter int CNT_W = 10
);
  logic             enable;
  logic             pwm_in;
  logic [CNT_W-1:0] high_count;
  logic [CNT_W-1:0] period_count;
  logic             valid;
  logic             timeout;
  logic             stuck_level;

  modport master (
    output enable, pwm_in,
    input  high_count, period_count, valid, timeout, stuck_level
  );

  modport slave (
    input  enable, pwm_in,
    output high_count, period_count, valid, timeout, stuck_level
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an external PWM line.
//   clock : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : pwm_capture_if.slave (enable, pwm_in in; counts, valid,
//           timeout, stuck_level out)
// Path from pwm_in to valid is SYNC_STAGES synchroniser flops, one edge
// detect register and the registered FSM output. SYNC_STAGES must be 2 or 3.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | disabled, counters held at 0
// ST_ARM  | waiting for the first rising edge; per_ctr counts idle cycles
// ST_MEAS | counting period and high time between rising edges
module pwm_capture #(
  parameter int CNT_W       = 10,
  parameter int SYNC_STAGES = 2
) (
  input logic          clock,
  input logic          reset,
  pwm_capture_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_MEAS} state_t;

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic                   r_rise;
  logic                   r_s_q;
  logic                   w_s;
  logic                   w_rise;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_per_ctr;
  logic [CNT_W-1:0]       r_hi_ctr;
  logic [CNT_W-1:0]       r_high_count;
  logic [CNT_W-1:0]       r_period_count;
  logic                   r_valid;
  logic                   r_timeout;
  logic                   r_stuck_level;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_s_d;

  // r_rise and r_s_q are the edge flag and the level it belongs to, kept on
  // the same stage so both edges of the input see identical delay.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
      r_rise <= 1'b0;
      r_s_q  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.pwm_in};
      r_s_d  <= w_s;
      r_rise <= w_rise;
      r_s_q  <= w_s;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_per_ctr      <= '0;
      r_hi_ctr       <= '0;
      r_high_count   <= '0;
      r_period_count <= '0;
      r_valid        <= 1'b0;
      r_timeout      <= 1'b0;
      r_stuck_level  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!bus.enable) begin
        r_state   <= ST_IDLE;
        r_per_ctr <= '0;
        r_hi_ctr  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_per_ctr <= '0;
            r_hi_ctr  <= '0;
            r_state   <= ST_ARM;
          end
          ST_ARM: begin
            if (r_rise) begin
              r_per_ctr <= ONE;
              r_hi_ctr  <= ONE;
              r_timeout <= 1'b0;
              r_state   <= ST_MEAS;
            end else if (r_per_ctr == MAX) begin
              // restart the idle count so a lasting fault re-samples the level
              r_timeout     <= 1'b1;
              r_stuck_level <= r_s_q;
              r_per_ctr     <= '0;
            end else begin
              r_per_ctr <= r_per_ctr + ONE;
            end
          end
          ST_MEAS: begin
            // a rise on the same edge as saturation still reports the period
            if (r_rise) begin
              r_high_count   <= r_hi_ctr;
              r_period_count <= r_per_ctr;
              r_valid        <= 1'b1;
              r_per_ctr      <= ONE;
              r_hi_ctr       <= ONE;
              r_timeout      <= 1'b0;
            end else if (r_per_ctr == MAX) begin
              r_timeout     <= 1'b1;
              r_stuck_level <= r_s_q;
              r_per_ctr     <= '0;
              r_hi_ctr      <= '0;
              r_state       <= ST_ARM;
            end else begin
              r_per_ctr <= r_per_ctr + ONE;
              if (r_s_q && (r_hi_ctr != MAX)) r_hi_ctr <= r_hi_ctr + ONE;
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_per_ctr <= '0;
            r_hi_ctr  <= '0;
          end
        endcase
      end
    end
  end

  assign bus.high_count   = r_high_count;
  assign bus.period_count = r_period_count;
  assign bus.valid        = r_valid;
  assign bus.timeout      = r_timeout;
  assign bus.stuck_level  = r_stuck_level;

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;

  localparam int CNT_W = 10;
  localparam int LAT   = 4;   // cycles from the drive cycle of a rise to valid

  typedef struct {
    int hi;
    int lo;
    int n;
    int exp_hc;
    int exp_pc;
  } row_t;

  typedef struct {
    int hc;
    int pc;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  bit   have_prev = 1'b0;
  int   prev_hc = 0;
  int   prev_pc = 0;
  bit   prev_valid = 1'b0;
  row_t rows[4];

  pwm_capture_if #(.CNT_W(CNT_W)) bus ();

  pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One PWM period starting with a rise. The rise closes the previous
  // period, so its expected measurement is queued now.
  task automatic period(input int hi, input int lo, input int ehc, input int epc);
    exp_t e;
    if (have_prev) begin
      e.hc = prev_hc; e.pc = prev_pc; e.cyc = cyc + LAT;
      q.push_back(e);
    end
    have_prev = 1'b1;
    prev_hc = ehc;
    prev_pc = epc;
    bus.pwm_in = 1'b1;
    step(hi);
    bus.pwm_in = 1'b0;
    step(lo);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_hc"},    int'(bus.high_count), 0);
    check({tag, "_pc"},    int'(bus.period_count), 0);
    check({tag, "_valid"}, int'(bus.valid), 0);
    check({tag, "_tmo"},   int'(bus.timeout), 0);
    check({tag, "_stuck"}, int'(bus.stuck_level), 0);
  endtask

  // Scoreboard side: every valid must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("no_x", int'($isunknown({bus.high_count, bus.period_count, bus.valid,
                                    bus.timeout, bus.stuck_level})), 0);
      if (bus.valid) begin
        check("strobe_one_cycle", int'(prev_valid), 0);
        check("hc_le_pc", int'(bus.high_count <= bus.period_count), 1);
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid actual hc=%0d pc=%0d required=no valid (cycle %0d)",
                   bus.high_count, bus.period_count, cyc);
        end else begin
          e = q.pop_front();
          check("high_count",   int'(bus.high_count), e.hc);
          check("period_count", int'(bus.period_count), e.pc);
          check("latency_cyc",  cyc, e.cyc);
        end
      end
      prev_valid = bus.valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    int c;
    rows[0] = '{hi: 3,  lo: 7,    n: 6, exp_hc: 3,  exp_pc: 10};
    rows[1] = '{hi: 10, lo: 22,   n: 3, exp_hc: 10, exp_pc: 32};
    rows[2] = '{hi: 1,  lo: 5,    n: 6, exp_hc: 1,  exp_pc: 6};
    rows[3] = '{hi: 1,  lo: 1022, n: 2, exp_hc: 1,  exp_pc: 1023};

    bus.enable = 1'b0;
    bus.pwm_in = 1'b0;
    rst = 1'b1;
    #1;
    check_zero_outputs("reset");
    step(3);
    rst = 1'b0;
    step(2);
    bus.enable = 1'b1;
    step(3);

    // Periodic waveforms, including the 1-cycle pulse and the period that
    // ends exactly when the counter reaches its maximum.
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < rows[r].n; k++)
        period(rows[r].hi, rows[r].lo, rows[r].exp_hc, rows[r].exp_pc);
    check("no_timeout_at_max_period", int'(bus.timeout), 0);

    // Stuck-high line: rise closes the last table period, then timeout.
    begin
      exp_t e;
      e.hc = prev_hc; e.pc = prev_pc; e.cyc = cyc + LAT;
      q.push_back(e);
    end
    have_prev = 1'b0;
    bus.pwm_in = 1'b1;
    c = cyc;
    while (cyc < c + 1026) step(1);
    @(negedge clk);
    check("timeout_before_1023", int'(bus.timeout), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("timeout_at_1023", int'(bus.timeout), 1);
    check("stuck_level_high", int'(bus.stuck_level), 1);
    while (cyc < c + 1100) step(1);
    check("timeout_sticky", int'(bus.timeout), 1);
    bus.pwm_in = 1'b0;
    step(5);
    period(5, 5, 5, 10);
    check("timeout_cleared", int'(bus.timeout), 0);
    period(5, 5, 5, 10);
    period(5, 5, 5, 10);
    step(8);

    // Asynchronous reset in the middle of a high phase.
    bus.pwm_in = 1'b1;
    step(1);
    #3;
    rst = 1'b1;
    #1;
    check_zero_outputs("async_reset");
    q.delete();
    have_prev = 1'b0;
    bus.pwm_in = 1'b0;
    #3;
    rst = 1'b0;
    step(3);
    period(4, 6, 4, 10);
    period(4, 6, 4, 10);
    period(4, 6, 4, 10);

    // Enable dropped between rises: outputs hold, no valid.
    bus.enable = 1'b0;
    step(2);
    bus.pwm_in = 1'b1;
    step(3);
    bus.pwm_in = 1'b0;
    step(6);
    check("disable_hold_hc", int'(bus.high_count), 4);
    check("disable_hold_pc", int'(bus.period_count), 10);
    check("disable_tmo", int'(bus.timeout), 0);
    bus.enable = 1'b1;
    have_prev = 1'b0;
    step(2);
    period(2, 8, 2, 10);
    check("reenable_first_rise_holds_hc", int'(bus.high_count), 4);
    period(2, 8, 2, 10);
    period(2, 8, 2, 10);
    step(10);

    check("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
